// File: rtl/display_decoder_pkg.sv
// Shared definitions for the multiplexed seven-segment display decoder and encoder:
// FSM state encoding, segment patterns (active-high gfedcba) and bus idle levels.
package display_decoder_pkg;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } dec_state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [7:0] SEG_BUS_IDLE = 8'hFF;
    localparam logic [3:0] DIG_IDLE     = 4'hF;

    // Returns {valid, index} for an active-low one-hot digit select.
    function automatic logic [2:0] digit_index(input logic [3:0] dig_n);
        logic [2:0] res;
        case (dig_n)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/display_decoder_seg7_to_bcd.sv
// Combinational seven-segment pattern to digit value lookup.
// An all-off pattern is reported as blank with value 0; anything unknown is invalid.
module seg7_to_bcd
    import display_decoder_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       blank,
    output logic       invalid
);

    // Pattern lookup
    always_comb begin
        value   = 4'd0;
        blank   = 1'b0;
        invalid = 1'b0;
        case (pattern)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/display_decoder.sv
// Recovers the time shown on a multiplexed 4-digit clock display by sniffing its
// segment/digit scan bus, debouncing each slot and confirming repeated frames.
module display_decoder
    import display_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int CONFIRM_FRAMES = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic [7:0] i_Segments,
    input  logic [3:0] i_Digits,
    output logic [1:0] o_Data_Dig1,
    output logic [3:0] o_Data_Dig2,
    output logic [2:0] o_Data_Dig3,
    output logic [3:0] o_Data_Dig4,
    output logic [3:0] o_Blank,
    output logic       o_Dot,
    output logic       o_Frame,
    output logic       o_Error,
    output logic       o_Lost
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int CW = $clog2(CONFIRM_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0]  seg_meta_r, seg_sync_r;
    logic [3:0]  dig_meta_r, dig_sync_r;
    logic [11:0] sample_s, last_sample_r;
    logic [SW-1:0] stab_cnt_r;
    logic        stable_hit_s;

    logic [6:0]  pattern_s;
    logic [3:0]  dec_value_s;
    logic        dec_blank_s, dec_invalid_s;
    logic [2:0]  dig_sel_s;
    logic [1:0]  dig_idx_s;
    logic        dig_valid_s, gap_s, range_err_s;
    logic        accept_s, err_s, timeout_s;

    dec_state_t     state_r;
    logic [3:0]     mask_r;
    logic [3:0][3:0] frame_val_r;
    logic [3:0]     frame_blank_r, frame_dot_r;
    logic [23:0]    frame_vec_s, prev_frame_r;
    logic [CW-1:0]  match_r, match_next_s;
    logic           confirm_s;
    logic [TW-1:0]  to_cnt_r;

    logic [1:0] data_dig1_r;
    logic [3:0] data_dig2_r;
    logic [2:0] data_dig3_r;
    logic [3:0] data_dig4_r;
    logic [3:0] blank_r;
    logic       dot_r, frame_r, error_r, lost_r;

    // Two-flop synchronizer for the asynchronous scan bus
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            seg_meta_r <= SEG_BUS_IDLE;
            seg_sync_r <= SEG_BUS_IDLE;
            dig_meta_r <= DIG_IDLE;
            dig_sync_r <= DIG_IDLE;
        end else begin
            seg_meta_r <= i_Segments;
            seg_sync_r <= seg_meta_r;
            dig_meta_r <= i_Digits;
            dig_sync_r <= dig_meta_r;
        end
    end

    assign sample_s = {seg_sync_r, dig_sync_r};

    // Stability counter: counts identical samples, saturating so a held slot fires once
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            last_sample_r <= {SEG_BUS_IDLE, DIG_IDLE};
            stab_cnt_r    <= SW'(0);
        end else begin
            last_sample_r <= sample_s;
            if (sample_s != last_sample_r) begin
                stab_cnt_r <= SW'(1);
            end else if (stab_cnt_r != SW'(STABLE_CYCLES)) begin
                stab_cnt_r <= stab_cnt_r + SW'(1);
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end
    end

    assign stable_hit_s = (sample_s == last_sample_r) &&
                          (stab_cnt_r == SW'(STABLE_CYCLES - 1));

    assign pattern_s = ~seg_sync_r[6:0];

    seg7_to_bcd u_seg7_to_bcd (
        .pattern (pattern_s),
        .value   (dec_value_s),
        .blank   (dec_blank_s),
        .invalid (dec_invalid_s)
    );

    assign dig_sel_s   = digit_index(dig_sync_r);
    assign dig_valid_s = dig_sel_s[2];
    assign dig_idx_s   = dig_sel_s[1:0];
    assign gap_s       = (dig_sync_r == DIG_IDLE);
    assign range_err_s = ((dig_idx_s == 2'd0) && (dec_value_s > 4'd3)) ||
                         ((dig_idx_s == 2'd2) && (dec_value_s > 4'd7));

    // Slot classification: a stable non-gap sample is either accepted or flagged
    always_comb begin
        accept_s = 1'b0;
        err_s    = 1'b0;
        if (stable_hit_s && !gap_s) begin
            if (!dig_valid_s || dec_invalid_s || range_err_s) begin
                err_s = 1'b1;
            end else begin
                accept_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            err_s    = 1'b0;
        end
    end

    assign frame_vec_s = {frame_val_r, frame_blank_r, frame_dot_r};
    assign timeout_s   = !accept_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Frame match counting, saturating at the confirmation threshold
    always_comb begin
        match_next_s = CW'(1);
        if (frame_vec_s == prev_frame_r) begin
            if (match_r == CW'(CONFIRM_FRAMES)) begin
                match_next_s = match_r;
            end else begin
                match_next_s = match_r + CW'(1);
            end
        end else begin
            match_next_s = CW'(1);
        end
    end

    assign confirm_s = (match_next_s == CW'(CONFIRM_FRAMES));

    // Frame assembly FSM with timeout supervision and registered outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r       <= ST_SYNC;
            mask_r        <= 4'b0000;
            frame_val_r   <= '0;
            frame_blank_r <= 4'b0000;
            frame_dot_r   <= 4'b0000;
            prev_frame_r  <= 24'd0;
            match_r       <= CW'(0);
            to_cnt_r      <= TW'(0);
            data_dig1_r   <= 2'd0;
            data_dig2_r   <= 4'd0;
            data_dig3_r   <= 3'd0;
            data_dig4_r   <= 4'd0;
            blank_r       <= 4'b0000;
            dot_r         <= 1'b0;
            frame_r       <= 1'b0;
            error_r       <= 1'b0;
            lost_r        <= 1'b1;
        end else begin
            frame_r <= 1'b0;
            error_r <= err_s;

            if (accept_s || timeout_s) begin
                to_cnt_r <= TW'(0);
            end else begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end

            if (accept_s && ((state_r == ST_COLLECT) ||
                             ((state_r == ST_SYNC) && (dig_idx_s == 2'd0)))) begin
                frame_val_r[dig_idx_s]   <= dec_value_s;
                frame_blank_r[dig_idx_s] <= dec_blank_s;
                frame_dot_r[dig_idx_s]   <= ~seg_sync_r[7];
            end

            if (timeout_s) begin
                lost_r  <= 1'b1;
                mask_r  <= 4'b0000;
                match_r <= CW'(0);
                state_r <= ST_SYNC;
            end else begin
                case (state_r)
                    ST_SYNC: begin
                        if (accept_s && (dig_idx_s == 2'd0)) begin
                            mask_r  <= 4'b0001;
                            state_r <= ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        if (accept_s) begin
                            if (dig_idx_s == 2'd0) begin
                                mask_r <= 4'b0001;
                            end else begin
                                mask_r <= mask_r | (4'b0001 << dig_idx_s);
                                if ((mask_r | (4'b0001 << dig_idx_s)) == 4'b1111) begin
                                    state_r <= ST_CHECK;
                                end
                            end
                        end
                    end
                    ST_CHECK: begin
                        prev_frame_r <= frame_vec_s;
                        match_r      <= match_next_s;
                        mask_r       <= 4'b0000;
                        state_r      <= ST_COLLECT;
                        if (confirm_s) begin
                            data_dig1_r <= frame_val_r[0][1:0];
                            data_dig2_r <= frame_val_r[1];
                            data_dig3_r <= frame_val_r[2][2:0];
                            data_dig4_r <= frame_val_r[3];
                            blank_r     <= frame_blank_r;
                            dot_r       <= |frame_dot_r;
                            frame_r     <= 1'b1;
                            lost_r      <= 1'b0;
                        end
                    end
                    default: begin
                        mask_r  <= 4'b0000;
                        state_r <= ST_SYNC;
                    end
                endcase
            end
        end
    end

    assign o_Data_Dig1 = data_dig1_r;
    assign o_Data_Dig2 = data_dig2_r;
    assign o_Data_Dig3 = data_dig3_r;
    assign o_Data_Dig4 = data_dig4_r;
    assign o_Blank     = blank_r;
    assign o_Dot       = dot_r;
    assign o_Frame     = frame_r;
    assign o_Error     = error_r;
    assign o_Lost      = lost_r;

endmodule

// File: tb/tb_display_decoder.sv
// Directed bench for display_decoder: scans display frames on the bus and checks
// decoded outputs, pulse counts, error handling, timeout and reset behaviour.
module tb_display_decoder;

    localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P3 = 7'h4F, P4 = 7'h66;
    localparam logic [6:0] P5 = 7'h6D, P8 = 7'h7F, P9 = 7'h6F, PB = 7'h00, PX = 7'h49;

    logic       clk_10mhz = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg = 8'hFF;
    logic [3:0] dig = 4'hF;
    logic [1:0] d1;
    logic [3:0] d2;
    logic [2:0] d3;
    logic [3:0] d4;
    logic [3:0] blank;
    logic       dot, frame, error, lost;

    int total = 0;
    int bad = 0;
    int frame_cnt = 0;
    int err_cnt = 0;

    always #50 clk_10mhz = ~clk_10mhz;

    display_decoder dut (
        .i_Clock     (clk_10mhz),
        .i_Reset     (rst),
        .i_Segments  (seg),
        .i_Digits    (dig),
        .o_Data_Dig1 (d1),
        .o_Data_Dig2 (d2),
        .o_Data_Dig3 (d3),
        .o_Data_Dig4 (d4),
        .o_Blank     (blank),
        .o_Dot       (dot),
        .o_Frame     (frame),
        .o_Error     (error),
        .o_Lost      (lost)
    );

    always @(negedge clk_10mhz) begin
        if (frame === 1'b1) frame_cnt++;
        if (error === 1'b1) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] enc(input logic [6:0] pat, input logic dp);
        return {~dp, ~pat};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_10mhz);
    endtask

    task automatic clear_counts();
        @(posedge clk_10mhz);
        frame_cnt = 0;
        err_cnt = 0;
        @(negedge clk_10mhz);
    endtask

    task automatic do_reset();
        @(negedge clk_10mhz);
        rst = 1'b1;
        seg = 8'hFF;
        dig = 4'hF;
        cycles(3);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic slot(input logic [6:0] pat, input logic dp, input int d);
        @(negedge clk_10mhz);
        seg = enc(pat, dp);
        dig = ~(4'b0001 << d);
        cycles(8);
        dig = 4'hF;
        cycles(3);
    endtask

    task automatic scan_frame(input logic [6:0] a, input logic [6:0] b,
                              input logic [6:0] c, input logic [6:0] e, input logic dp2);
        slot(a, 1'b0, 0);
        slot(b, dp2, 1);
        slot(c, 1'b0, 2);
        slot(e, 1'b0, 3);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({d1, d2, d3, d4} !== 13'd0) begin
            $display("FAIL reset_data: got %h want 0", {d1, d2, d3, d4}); bad++;
        end
        total++;
        if ({blank, dot, frame, error} !== 7'd0) begin
            $display("FAIL reset_flags: got %b want 0000000", {blank, dot, frame, error}); bad++;
        end
        total++;
        if (lost !== 1'b1) begin
            $display("FAIL reset_lost: got %b want 1", lost); bad++;
        end
    endtask

    task automatic test_basic();
        do_reset();
        clear_counts();
        scan_frame(P1, P2, P3, P4, 1'b0);
        cycles(2);
        total++;
        if (frame_cnt !== 0 || lost !== 1'b1) begin
            $display("FAIL basic_first_frame: frames=%0d lost=%b want 0 and 1", frame_cnt, lost); bad++;
        end
        scan_frame(P1, P2, P3, P4, 1'b0);
        cycles(2);
        total++;
        if (frame_cnt !== 1) begin
            $display("FAIL basic_frames: got %0d want 1", frame_cnt); bad++;
        end
        total++;
        if ({d1, d2, d3, d4} !== {2'd1, 4'd2, 3'd3, 4'd4}) begin
            $display("FAIL basic_data: got %0d%0d:%0d%0d want 12:34", d1, d2, d3, d4); bad++;
        end
        total++;
        if ({blank, dot, lost, err_cnt == 0} !== 7'b0000001) begin
            $display("FAIL basic_flags: blank=%b dot=%b lost=%b errs=%0d want 0000 0 0 0",
                     blank, dot, lost, err_cnt); bad++;
        end
    endtask

    task automatic test_blink();
        do_reset();
        clear_counts();
        for (int i = 0; i < 2; i++) begin
            scan_frame(P1, P2, P3, P4, 1'b0);
            scan_frame(PB, PB, P3, P4, 1'b0);
        end
        cycles(2);
        total++;
        if (frame_cnt !== 0 || lost !== 1'b1) begin
            $display("FAIL blink_alternate: frames=%0d lost=%b want 0 and 1", frame_cnt, lost); bad++;
        end
        scan_frame(PB, PB, P3, P4, 1'b0);
        cycles(2);
        total++;
        if (frame_cnt !== 1) begin
            $display("FAIL blink_frames: got %0d want 1", frame_cnt); bad++;
        end
        total++;
        if (blank !== 4'b0011 || {d1, d2, d3, d4} !== {2'd0, 4'd0, 3'd3, 4'd4}) begin
            $display("FAIL blink_blank: blank=%b data=%0d%0d:%0d%0d want 0011 00:34",
                     blank, d1, d2, d3, d4); bad++;
        end
    endtask

    task automatic test_bad_pattern();
        do_reset();
        scan_frame(P1, P2, P3, P4, 1'b0);
        scan_frame(P1, P2, P3, P4, 1'b0);
        cycles(2);
        clear_counts();
        slot(P1, 1'b0, 0);
        slot(P2, 1'b0, 1);
        @(negedge clk_10mhz);
        seg = enc(PX, 1'b0);
        dig = 4'b1011;
        cycles(20);
        dig = 4'hF;
        cycles(10);
        total++;
        if (err_cnt !== 1) begin
            $display("FAIL badpat_errors: got %0d want 1", err_cnt); bad++;
        end
        total++;
        if (frame_cnt !== 0) begin
            $display("FAIL badpat_frames: got %0d want 0", frame_cnt); bad++;
        end
        total++;
        if ({d1, d2, d3, d4} !== {2'd1, 4'd2, 3'd3, 4'd4} || lost !== 1'b0) begin
            $display("FAIL badpat_hold: data=%0d%0d:%0d%0d lost=%b want 12:34 0", d1, d2, d3, d4, lost); bad++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        clear_counts();
        for (int i = 0; i < 2; i++) begin
            slot(P1, 1'b0, 0);
            @(negedge clk_10mhz);
            seg = enc(PX, 1'b0);
            dig = 4'b1101;
            cycles(1);
            dig = 4'hF;
            cycles(2);
            slot(P2, 1'b0, 1);
            slot(P3, 1'b0, 2);
            slot(P4, 1'b0, 3);
        end
        cycles(2);
        total++;
        if (err_cnt !== 0 || frame_cnt !== 1) begin
            $display("FAIL glitch_ignored: errs=%0d frames=%0d want 0 and 1", err_cnt, frame_cnt); bad++;
        end
        total++;
        if ({d1, d2, d3, d4} !== {2'd1, 4'd2, 3'd3, 4'd4}) begin
            $display("FAIL glitch_data: got %0d%0d:%0d%0d want 12:34", d1, d2, d3, d4); bad++;
        end
        @(negedge clk_10mhz);
        seg = enc(P5, 1'b0);
        dig = 4'b0000;
        cycles(12);
        dig = 4'hF;
        cycles(3);
        total++;
        if (err_cnt !== 1) begin
            $display("FAIL multi_digit_error: got %0d want 1", err_cnt); bad++;
        end
    endtask

    task automatic test_range();
        do_reset();
        clear_counts();
        slot(P5, 1'b0, 0);
        slot(P8, 1'b0, 2);
        slot(P9, 1'b0, 1);
        total++;
        if (err_cnt !== 2) begin
            $display("FAIL range_errors: got %0d want 2", err_cnt); bad++;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        scan_frame(P1, P2, P3, P4, 1'b0);
        scan_frame(P1, P2, P3, P4, 1'b0);
        cycles(900);
        total++;
        if (lost !== 1'b0) begin
            $display("FAIL timeout_early: lost=%b want 0", lost); bad++;
        end
        cycles(200);
        total++;
        if (lost !== 1'b1 || {d1, d2, d3, d4} !== {2'd1, 4'd2, 3'd3, 4'd4}) begin
            $display("FAIL timeout_lost: lost=%b data=%0d%0d:%0d%0d want 1 12:34", lost, d1, d2, d3, d4); bad++;
        end
        clear_counts();
        scan_frame(P2, P3, P5, P9, 1'b1);
        cycles(2);
        total++;
        if (frame_cnt !== 0 || lost !== 1'b1) begin
            $display("FAIL resume_first: frames=%0d lost=%b want 0 and 1", frame_cnt, lost); bad++;
        end
        scan_frame(P2, P3, P5, P9, 1'b1);
        cycles(2);
        total++;
        if (frame_cnt !== 1 || lost !== 1'b0) begin
            $display("FAIL resume_confirm: frames=%0d lost=%b want 1 and 0", frame_cnt, lost); bad++;
        end
        total++;
        if ({d1, d2, d3, d4} !== {2'd2, 4'd3, 3'd5, 4'd9} || dot !== 1'b1) begin
            $display("FAIL resume_data: data=%0d%0d:%0d%0d dot=%b want 23:59 1", d1, d2, d3, d4, dot); bad++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        scan_frame(P1, P2, P3, P4, 1'b0);
        scan_frame(P1, P2, P3, P4, 1'b0);
        cycles(2);
        clear_counts();
        slot(P1, 1'b0, 0);
        slot(P2, 1'b0, 1);
        @(negedge clk_10mhz);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        total++;
        if ({d1, d2, d3, d4} !== 13'd0 || blank !== 4'b0000 || dot !== 1'b0) begin
            $display("FAIL midreset_data: data=%h blank=%b dot=%b want 0", {d1, d2, d3, d4}, blank, dot); bad++;
        end
        total++;
        if (lost !== 1'b1) begin
            $display("FAIL midreset_lost: got %b want 1", lost); bad++;
        end
        slot(P3, 1'b0, 2);
        slot(P4, 1'b0, 3);
        cycles(5);
        total++;
        if (frame_cnt !== 0 || {d1, d2, d3, d4} !== 13'd0) begin
            $display("FAIL midreset_frame: frames=%0d data=%h want 0 and 0", frame_cnt, {d1, d2, d3, d4}); bad++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blink();
        test_bad_pattern();
        test_glitch();
        test_range();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
